// File: rtl/dest_reg_tracker_pkg.sv
// Shared encodings and defaults for the destination-register tracker.
// Also holds the rule for which pipeline stages can raise a decode stall.
package dest_reg_tracker_pkg;

    localparam int DEF_REG_AW   = 5;
    localparam int DEF_DEPTH    = 3;
    localparam int DEF_LINK_REG = 31;

    typedef enum logic [1:0] {
        DSEL_RD   = 2'b00,
        DSEL_RT   = 2'b01,
        DSEL_LINK = 2'b10,
        DSEL_NONE = 2'b11
    } dsel_e;

    // With forwarding only a load sitting in EX is unavailable to the next
    // instruction; without forwarding everything before WB is unavailable,
    // and WB itself is fine because the register file writes before it reads.
    function automatic bit stage_can_stall(input int fwd, input int k, input int depth);
        if (fwd != 0) begin
            return (k == 0);
        end
        return (k < depth - 1);
    endfunction

endpackage

// File: rtl/dest_reg_tracker_if.sv
// ID-stage bundle between the decoder/hazard logic and the tracker.
// The slave side is the tracker; the master side is whatever drives decode.
interface dest_reg_tracker_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3
);
    logic                      id_valid;
    logic [REG_AW-1:0]         rt;
    logic [REG_AW-1:0]         rd;
    logic [1:0]                dest_sel;
    logic                      wreg;
    logic                      m2reg;
    logic                      rs_used;
    logic                      rt_used;
    logic [REG_AW-1:0]         rs_q;
    logic [REG_AW-1:0]         rt_q;
    logic                      flush;

    logic [REG_AW-1:0]         dest_reg;
    logic                      stall;
    logic [DEPTH-1:0]          stage_valid;
    logic [DEPTH*REG_AW-1:0]   stage_dest;
    logic [DEPTH-1:0]          stage_load;

    modport master (
        output id_valid, rt, rd, dest_sel, wreg, m2reg,
        output rs_used, rt_used, rs_q, rt_q, flush,
        input  dest_reg, stall, stage_valid, stage_dest, stage_load
    );

    modport slave (
        input  id_valid, rt, rd, dest_sel, wreg, m2reg,
        input  rs_used, rt_used, rs_q, rt_q, flush,
        output dest_reg, stall, stage_valid, stage_dest, stage_load
    );
endinterface

// File: rtl/dest_reg_tracker_stage_reg.sv
// One tracked pipeline slot {valid, dest, load}; cleared asynchronously by rst.
module dest_stage_reg #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [REG_AW-1:0] dest_i,
    input  logic              load_i,
    output logic              valid_o,
    output logic [REG_AW-1:0] dest_o,
    output logic              load_o
);

    logic              valid_q;
    logic [REG_AW-1:0] dest_q;
    logic              load_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dest_q  <= '0;
            load_q  <= 1'b0;
        end else begin
            valid_q <= valid_i;
            dest_q  <= dest_i;
            load_q  <= load_i;
        end
    end

    assign valid_o = valid_q;
    assign dest_o  = dest_q;
    assign load_o  = load_q;

endmodule

// File: rtl/dest_reg_tracker.sv
// Selects the decoding instruction's write destination, tracks pending writes
// through EX..WB, and raises a combinational RAW stall for the ID stage.
module dest_reg_tracker
    import dest_reg_tracker_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int LINK_REG = DEF_LINK_REG,
    parameter int FWD      = 1
) (
    input  logic              clk,
    input  logic              rst,
    dest_reg_tracker_if.slave bus
);

    localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);

    dsel_e              dsel;
    logic [REG_AW-1:0]  dest_sel_d;
    logic               writes_d;
    logic               stall_d;
    logic               bubble_d;
    logic               new_valid_d;

    logic [DEPTH-1:0]   stage_valid_q;
    logic [DEPTH-1:0]   stage_load_q;
    logic [REG_AW-1:0]  stage_dest_q [DEPTH];

    logic [DEPTH-1:0]   valid_d;
    logic [DEPTH-1:0]   load_d;
    logic [REG_AW-1:0]  dest_d [DEPTH];

    logic [DEPTH-1:0]   rs_hit;
    logic [DEPTH-1:0]   rt_hit;
    logic [DEPTH-1:0]   hazard;

    always_comb begin
        dsel       = dsel_e'(bus.dest_sel);
        dest_sel_d = '0;
        writes_d   = 1'b1;
        unique case (dsel)
            DSEL_RD:   dest_sel_d = bus.rd;
            DSEL_RT:   dest_sel_d = bus.rt;
            DSEL_LINK: dest_sel_d = LINK_ADDR;
            DSEL_NONE: writes_d   = 1'b0;
            default:   writes_d   = 1'b0;
        endcase
    end

    // stall is built only from stage registers and ID inputs, never from
    // itself, so there is no combinational loop through new_valid_d.
    assign stall_d     = bus.id_valid & ~bus.flush & (|hazard);
    assign bubble_d    = stall_d | bus.flush;
    assign new_valid_d = bus.id_valid & bus.wreg & writes_d & (dest_sel_d != '0)
                       & ~bus.flush & ~stall_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            localparam bit CAN_STALL = stage_can_stall(FWD, gi, DEPTH);
            localparam bit LOAD_ONLY = (FWD != 0);

            assign rs_hit[gi] = stage_valid_q[gi] & bus.rs_used
                              & (stage_dest_q[gi] == bus.rs_q) & (bus.rs_q != '0);
            assign rt_hit[gi] = stage_valid_q[gi] & bus.rt_used
                              & (stage_dest_q[gi] == bus.rt_q) & (bus.rt_q != '0);
            assign hazard[gi] = CAN_STALL & (rs_hit[gi] | rt_hit[gi])
                              & (~LOAD_ONLY | stage_load_q[gi]);

            if (gi == 0) begin : g_head
                assign valid_d[gi] = new_valid_d;
                assign dest_d[gi]  = bubble_d ? '0 : dest_sel_d;
                assign load_d[gi]  = bus.m2reg & new_valid_d;
            end else begin : g_shift
                assign valid_d[gi] = stage_valid_q[gi-1];
                assign dest_d[gi]  = stage_dest_q[gi-1];
                assign load_d[gi]  = stage_load_q[gi-1];
            end

            dest_stage_reg #(
                .REG_AW (REG_AW)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .valid_i (valid_d[gi]),
                .dest_i  (dest_d[gi]),
                .load_i  (load_d[gi]),
                .valid_o (stage_valid_q[gi]),
                .dest_o  (stage_dest_q[gi]),
                .load_o  (stage_load_q[gi])
            );

            assign bus.stage_dest[gi*REG_AW +: REG_AW] = stage_dest_q[gi];
        end
    endgenerate

    assign bus.dest_reg    = dest_sel_d;
    assign bus.stall       = stall_d;
    assign bus.stage_valid = stage_valid_q;
    assign bus.stage_load  = stage_load_q;

endmodule
